// File: rtl/audio_uart_streamer.sv
// Multi-channel audio sample framer: decimates strobed samples, queues frames,
// and serialises each as SYNC_BYTE plus MSB-first channel bytes over 8N1 UART.
//
// state | meaning
// IDLE  | line high, waiting for a queued frame
// LOAD  | pop head frame into the shift buffer
// START | start bit (0) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1), then next byte, next frame or idle
module audio_uart_streamer #(
    parameter int          NUM_CH       = 4,
    parameter int          SAMPLE_WIDTH = 24,
    parameter int          OUT_BYTES    = 2,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          BAUD_RATE    = 921_600,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     enable_in,
    input  logic [$clog2(NUM_CH+1)-1:0]              num_ch_in,
    input  logic [7:0]                               decim_in,
    input  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0]      audio_in,
    input  logic                                     valid_in,
    output logic                                     tx_wire_out,
    output logic                                     busy_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]          fifo_level_out,
    output logic [15:0]                              overflow_count_out
);
    localparam int CPB  = CLK_HZ / BAUD_RATE;
    localparam int TW   = $clog2(CPB + 1);
    localparam int NCW  = $clog2(NUM_CH + 1);
    localparam int LW   = $clog2(FIFO_DEPTH + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int OW   = OUT_BYTES * 8;
    localparam int PW   = NUM_CH * OW;
    localparam int FW   = NCW + PW;
    localparam int SBW  = PW + 8;
    localparam int BIW  = $clog2(NUM_CH * OUT_BYTES + 1);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(CPB - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t            state;
    logic [TW-1:0]     tmr;
    logic [2:0]        bit_idx;
    logic [BIW-1:0]    byte_idx;
    logic [BIW-1:0]    last_idx;
    logic [NCW-1:0]    cur_nch;
    logic [SBW-1:0]    sbuf;
    logic [7:0]        cur_byte;

    logic [7:0]        dec_cnt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [FW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]     head;
    logic [NCW-1:0]    nch;
    logic [PW-1:0]     payload;
    logic              accept;
    logic              keep;
    logic              full;
    logic              pop;
    logic              push;
    logic              unused_audio_bits;

    assign unused_audio_bits = ^audio_in;

    always_comb begin
        payload = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            payload[(NUM_CH-1-c)*OW +: OW] = audio_in[c][SAMPLE_WIDTH-1 -: OW];
        end
    end

    always_comb begin
        if (num_ch_in == '0)
            nch = NCW'(1);
        else if (num_ch_in > NCW'(NUM_CH))
            nch = NCW'(NUM_CH);
        else
            nch = num_ch_in;
    end

    assign accept   = valid_in && enable_in;
    assign keep     = accept && (dec_cnt == 8'd0);
    assign full     = (fifo_level_out == LW'(FIFO_DEPTH));
    assign pop      = (state == LOAD);
    // A full FIFO still takes the frame when LOAD frees a slot this cycle.
    assign push     = keep && (!full || pop);
    assign head     = fifo_mem[rd_ptr];
    assign cur_byte = sbuf[SBW-1 -: 8];
    assign last_idx = BIW'(cur_nch * OUT_BYTES);

    always_ff @(posedge clk_in) begin
        if (push)
            fifo_mem[wr_ptr] <= {nch, payload};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dec_cnt            <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            fifo_level_out     <= '0;
            overflow_count_out <= '0;
        end else begin
            if (accept)
                dec_cnt <= (dec_cnt >= decim_in) ? 8'd0 : dec_cnt + 8'd1;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_level_out <= fifo_level_out + LW'(1);
            else if (pop && !push)
                fifo_level_out <= fifo_level_out - LW'(1);
            if (keep && !push && overflow_count_out != 16'hFFFF)
                overflow_count_out <= overflow_count_out + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            tmr         <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            cur_nch     <= '0;
            sbuf        <= '0;
            tx_wire_out <= 1'b1;
            busy_out    <= 1'b0;
        end else begin
            if (push)
                busy_out <= 1'b1;
            case (state)
                IDLE: begin
                    if (fifo_level_out != '0)
                        state <= LOAD;
                end
                LOAD: begin
                    sbuf        <= {SYNC_BYTE, head[PW-1:0]};
                    cur_nch     <= head[FW-1 -: NCW];
                    byte_idx    <= '0;
                    tmr         <= TMR_RELOAD;
                    tx_wire_out <= 1'b0;
                    state       <= START;
                end
                START: begin
                    if (tmr == '0) begin
                        tmr         <= TMR_RELOAD;
                        bit_idx     <= '0;
                        tx_wire_out <= cur_byte[0];
                        state       <= DATA;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                DATA: begin
                    if (tmr == '0) begin
                        tmr <= TMR_RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx_wire_out <= 1'b1;
                            state       <= STOP;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            tx_wire_out <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                STOP: begin
                    if (tmr == '0) begin
                        if (byte_idx < last_idx) begin
                            byte_idx    <= byte_idx + BIW'(1);
                            sbuf        <= sbuf << 8;
                            tmr         <= TMR_RELOAD;
                            tx_wire_out <= 1'b0;
                            state       <= START;
                        end else if (fifo_level_out != '0) begin
                            state <= LOAD;
                        end else begin
                            state    <= IDLE;
                            busy_out <= push;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_uart_streamer.sv
// Bench for audio_uart_streamer: waveform-level reference model compared every
// cycle, a UART receiver for literal byte checks, directed and random stimulus.
module tb_audio_uart_streamer;
    localparam int NUM_CH = 4;
    localparam int SW     = 24;
    localparam int DEPTH  = 8;
    localparam int CPB    = 16;   // 100 MHz / 6 Mbaud = 16.67, truncated

    logic                          clk_in = 1'b0;
    logic                          rst_in = 1'b1;
    logic                          enable_in = 1'b0;
    logic                          valid_in = 1'b0;
    logic [2:0]                    num_ch_in = 3'd1;
    logic [7:0]                    decim_in = 8'd0;
    logic [NUM_CH-1:0][SW-1:0]     audio_in = '0;
    logic                          tx_wire_out;
    logic                          busy_out;
    logic [3:0]                    fifo_level_out;
    logic [15:0]                   overflow_count_out;

    audio_uart_streamer #(
        .NUM_CH(NUM_CH), .SAMPLE_WIDTH(SW), .OUT_BYTES(2), .FIFO_DEPTH(DEPTH),
        .CLK_HZ(100_000_000), .BAUD_RATE(6_000_000), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .num_ch_in(num_ch_in), .decim_in(decim_in), .audio_in(audio_in),
        .valid_in(valid_in), .tx_wire_out(tx_wire_out), .busy_out(busy_out),
        .fifo_level_out(fifo_level_out), .overflow_count_out(overflow_count_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;
    int printed = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: frames as byte lists, transmitter as a queue of line levels.
    logic [71:0] q_bytes[$];
    int          q_len[$];
    logic        wave[$];
    bit          m_active, m_loading, m_keep;
    logic        m_tx = 1'b1;
    int          m_ovf, m_nacc, m_n, m_len;
    logic [71:0] m_fb;
    logic [7:0]  m_b;
    logic [15:0] m_top;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            q_bytes.delete(); q_len.delete(); wave.delete();
            m_active = 0; m_loading = 0; m_tx = 1'b1; m_ovf = 0; m_nacc = 0;
        end else begin
            if (m_loading) begin
                m_fb  = q_bytes.pop_front();
                m_len = q_len.pop_front();
                for (int i = 0; i < m_len; i++) begin
                    m_b = m_fb[71-8*i -: 8];
                    repeat (CPB) wave.push_back(1'b0);
                    for (int k = 0; k < 8; k++) repeat (CPB) wave.push_back(m_b[k]);
                    repeat (CPB) wave.push_back(1'b1);
                end
                m_tx = wave.pop_front();
                m_loading = 0;
                m_active = 1;
            end else if (m_active && wave.size() > 0) begin
                m_tx = wave.pop_front();
            end else begin
                m_active = 0;
                if (q_bytes.size() > 0) m_loading = 1;
            end
            if (valid_in && enable_in) begin
                m_keep = (m_nacc % (int'(decim_in) + 1)) == 0;
                m_nacc++;
                if (m_keep) begin
                    m_n = (num_ch_in == 0) ? 1 : ((num_ch_in > 4) ? 4 : int'(num_ch_in));
                    m_fb = '0;
                    m_fb[71:64] = 8'hA5;
                    for (int c = 0; c < m_n; c++) begin
                        m_top = audio_in[c][23:8];
                        m_fb[71-8*(1+2*c) -: 8] = m_top[15:8];
                        m_fb[71-8*(2+2*c) -: 8] = m_top[7:0];
                    end
                    if (q_bytes.size() < DEPTH) begin
                        q_bytes.push_back(m_fb);
                        q_len.push_back(1 + 2*m_n);
                    end else if (m_ovf < 65535) begin
                        m_ovf++;
                    end
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            bit exp_busy;
            exp_busy = m_active || m_loading || (q_bytes.size() != 0);
            vectors++;
            if (tx_wire_out !== m_tx || busy_out !== exp_busy ||
                int'(fifo_level_out) != q_bytes.size() || int'(overflow_count_out) != m_ovf) begin
                miscompares++;
                if (printed < 20) begin
                    printed++;
                    $display("FAIL cycle_cmp t=%0t: tx/busy/level/ovf got %b/%b/%0d/%0d, expected %b/%b/%0d/%0d",
                             $time, tx_wire_out, busy_out, fifo_level_out, overflow_count_out,
                             m_tx, exp_busy, q_bytes.size(), m_ovf);
                end
            end
        end
    end

    // Independent UART receiver, mid-bit sampling.
    logic [7:0] rx_q[$];
    bit         r_act = 0;
    int         r_cnt, r_k;
    logic [7:0] r_byte;
    int         peak = 0;

    always @(negedge clk_in) begin
        if (int'(fifo_level_out) > peak) peak = int'(fifo_level_out);
        if (rst_in) begin
            r_act = 0;
        end else if (!r_act) begin
            if (tx_wire_out == 1'b0) begin r_act = 1; r_cnt = 0; end
        end else begin
            r_cnt++;
            if (r_cnt >= CPB + CPB/2 && ((r_cnt - CPB/2) % CPB) == 0) begin
                r_k = (r_cnt - CPB/2) / CPB;
                if (r_k <= 8) r_byte[r_k-1] = tx_wire_out;
                else begin rx_q.push_back(r_byte); r_act = 0; end
            end
        end
    end

    task automatic strobe(input logic [NUM_CH-1:0][SW-1:0] a, input bit en);
        @(negedge clk_in);
        audio_in = a; enable_in = en; valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while ((busy_out || r_act) && t < budget) begin @(negedge clk_in); t++; end
        if (t >= budget) begin
            vectors++; miscompares++;
            $display("FAIL %s: still busy after %0d cycles, required drained", name, t);
        end
        repeat (3) @(negedge clk_in);
    endtask

    task automatic check_rx(input string name, input int idx, input int exp);
        if (idx >= rx_q.size()) begin
            vectors++; miscompares++;
            $display("FAIL %s: byte %0d missing, required 0x%0h", name, idx, exp);
        end else check(name, int'(rx_q[idx]), exp);
    endtask

    task automatic pulse_reset();
        @(negedge clk_in); #2 rst_in = 1'b1;
        @(negedge clk_in); #2 rst_in = 1'b0;
    endtask

    logic [NUM_CH-1:0][SW-1:0] a4, a;
    int lat, cnt;
    int exp9[9] = '{8'hA5, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};

    initial begin
        a4 = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b0;
        @(negedge clk_in);
        check("reset_tx", tx_wire_out, 1);
        check("reset_busy", busy_out, 0);
        check("reset_level", fifo_level_out, 0);
        check("reset_ovf", overflow_count_out, 0);

        // Single channel, latency and frame length.
        num_ch_in = 3'd1;
        a = '0; a[0] = 24'h123456;
        strobe(a, 1'b1);
        for (lat = 1; lat <= 8; lat++) begin
            @(posedge clk_in); #1;
            if (!tx_wire_out) break;
        end
        check("start_latency", lat, 2);
        cnt = 0;
        while (busy_out && cnt < 5000) begin @(posedge clk_in); #1; cnt++; end
        check("frame_cycles", cnt, 3 * 10 * CPB);
        wait_drain("t1_drain", 2000);
        check("t1_count", rx_q.size(), 3);
        check_rx("t1_b0", 0, 8'hA5);
        check_rx("t1_b1", 1, 8'h12);
        check_rx("t1_b2", 2, 8'h34);

        // Four channels, clamp above NUM_CH, zero treated as one.
        for (int pass = 0; pass < 2; pass++) begin
            rx_q.delete();
            num_ch_in = (pass == 0) ? 3'd4 : 3'd7;
            strobe(a4, 1'b1);
            wait_drain("t2_drain", 4000);
            check("t2_count", rx_q.size(), 9);
            for (int i = 0; i < 9; i++) check_rx("t2_byte", i, exp9[i]);
        end
        rx_q.delete();
        num_ch_in = 3'd0;
        strobe(a4, 1'b1);
        wait_drain("t2z_drain", 2000);
        check("t2z_count", rx_q.size(), 3);
        check_rx("t2z_b1", 1, 8'h11);

        // Overflow: 20 strobes spaced 10 cycles.
        rx_q.delete(); peak = 0;
        num_ch_in = 3'd4;
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < NUM_CH; c++) a[c] = 24'($urandom);
            strobe(a, 1'b1);
            repeat (8) @(negedge clk_in);
        end
        check("ovf_peak", peak, 8);
        check("ovf_count", overflow_count_out, 11);
        wait_drain("ovf_drain", 20000);
        check("ovf_bytes", rx_q.size(), 81);
        for (int f = 0; f < 9; f++) check_rx("ovf_sync", 9*f, 8'hA5);

        // Channel count latched per frame.
        rx_q.delete();
        strobe(a4, 1'b1);
        @(negedge clk_in); num_ch_in = 3'd1;
        a = '0; a[0] = 24'hABCDEF;
        strobe(a, 1'b1);
        wait_drain("nch_drain", 5000);
        check("nch_count", rx_q.size(), 12);
        check_rx("nch_f1", 7, 8'h44);
        check_rx("nch_f2s", 9, 8'hA5);
        check_rx("nch_f2h", 10, 8'hAB);
        check_rx("nch_f2l", 11, 8'hCD);

        // Asynchronous reset mid-DATA of frame 2.
        rx_q.delete();
        num_ch_in = 3'd4;
        repeat (3) strobe(a4, 1'b1);
        cnt = 0;
        while (rx_q.size() < 9 && cnt < 5000) begin @(negedge clk_in); cnt++; end
        check("rst_frame1_seen", rx_q.size(), 9);
        repeat (3 * CPB) @(negedge clk_in);
        check("rst_pre_level", fifo_level_out, 1);
        #2 rst_in = 1'b1;
        #1;
        check("rst_tx", tx_wire_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_level", fifo_level_out, 0);
        check("rst_ovf", overflow_count_out, 0);
        @(negedge clk_in); #2 rst_in = 1'b0;
        rx_q.delete();
        num_ch_in = 3'd1;
        a = '0; a[0] = 24'h5A5A5A;
        strobe(a, 1'b1);
        wait_drain("rst_drain", 2000);
        check("rst_count", rx_q.size(), 3);
        check_rx("rst_b0", 0, 8'hA5);
        check_rx("rst_b1", 1, 8'h5A);

        // Decimation by 4 with disabled strobes interleaved.
        pulse_reset();
        rx_q.delete();
        decim_in = 8'd3;
        for (int i = 1; i <= 12; i++) begin
            a = '0; a[0] = {8'(i), 16'h0};
            strobe(a, 1'b1);
            repeat (100) @(negedge clk_in);
            a[0] = 24'hEE0000;
            strobe(a, 1'b0);
            repeat (100) @(negedge clk_in);
        end
        wait_drain("dec_drain", 3000);
        check("dec_count", rx_q.size(), 9);
        check_rx("dec_f1", 1, 8'h01);
        check_rx("dec_f2", 4, 8'h05);
        check_rx("dec_f3", 7, 8'h09);
        check_rx("dec_f3l", 8, 8'h00);

        // Random traffic.
        pulse_reset();
        decim_in = 8'($urandom_range(0, 2));
        repeat (40) begin
            for (int c = 0; c < NUM_CH; c++) a[c] = 24'($urandom);
            num_ch_in = 3'($urandom_range(0, 7));
            strobe(a, $urandom_range(0, 4) != 0);
            repeat ($urandom_range(0, 300)) @(negedge clk_in);
        end
        enable_in = 1'b0;
        wait_drain("rand_drain", 20000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
